dc_useq: RTL and testbench

//  Microsequencer: the address-issuing end of the dc_rom interface. Drives the
//  ROM's 10-bit address (a_in incl. AX) and cen. Consumes the registered
//  ma/mc word one cycle later. Resolves next address (seq/branch/call/return/
//  PLA dispatch/trap). Presents the valid microword to the datapath.

---
 rtl/dc_useq_if.sv | 12 +
 rtl/dc_useq.sv | 138 +++++++++++++
 tb/tb_dc_useq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dc_useq_if.sv
// ROM-side bus of the microsequencer: address/enable out, registered
// next-address and microcode fields back one cycle later.
interface dc_useq_if;
    logic [9:0]  rom_a;
    logic        rom_cen;
    logic [8:0]  rom_ma;
    logic [15:0] rom_mc;

    // Sequencer side drives the address, ROM side returns the word.
    modport master (output rom_a, rom_cen, input rom_ma, rom_mc);
    modport slave  (input rom_a, rom_cen, output rom_ma, rom_mc);
endinterface

// File: rtl/dc_useq.sv
// Microsequencer: issues dc_rom addresses, resolves the next microaddress
// (sequential, branch, call, return, PLA dispatch, trap) and presents the
// fetched microword to the datapath. Small LIFO holds return addresses.
module dc_useq #(
    parameter int          STK_DEPTH  = 4,
    parameter logic [9:0]  RESET_ADDR = 10'h080
) (
    input  logic         clk,
    input  logic         nrst,
    dc_useq_if.master    rom,
    input  logic         ax,
    input  logic [8:0]   pla_adr,
    input  logic [3:0]   cond,
    input  logic         ready,
    input  logic         trap_req,
    input  logic [9:0]   trap_adr,
    output logic         trap_ack,
    output logic [15:0]  mc_out,
    output logic         mc_vld,
    output logic [9:0]   upc,
    output logic         stk_err
);

    localparam int CW = $clog2(STK_DEPTH + 1);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state_q, state_d;
    logic [9:0]    upc_q, upc_d;
    logic [9:0]    stk_q [STK_DEPTH];
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic [2:0]    op;
    logic [1:0]    cc;
    logic          exec;
    logic [9:0]    nxt;
    logic          push, pop, trap_take;
    logic [9:0]    push_val;
    logic [9:0]    rom_a_d;
    logic          cen_d;

    assign op   = rom.rom_mc[15:13];
    assign cc   = rom.rom_mc[14:13];
    // A word executes only once the sequencer is running and the datapath is ready.
    assign exec = (state_q == RUN) && ready;

    // Next-address resolution plus the single stack operation it implies.
    always_comb begin
        nxt       = {ax, rom.rom_ma};
        push      = 1'b0;
        pop       = 1'b0;
        trap_take = 1'b0;
        push_val  = upc_q + 10'd1;
        case (op)
            3'b000: nxt = {ax, rom.rom_ma};
            3'b001: push = exec;
            3'b010: begin
                pop = exec;
                // Return address carries its own AX bit; empty stack restarts.
                nxt = (cnt_q == '0) ? RESET_ADDR : stk_q[0];
            end
            3'b011: nxt = {ax, pla_adr};
            default: nxt = {ax, rom.rom_ma[8:1], rom.rom_ma[0] | cond[cc]};
        endcase
        // Traps only break into SEQ/BR words so a CALL/RET never loses its stack op.
        if (exec && trap_req && (op == 3'b000 || op[2])) begin
            trap_take = 1'b1;
            push      = 1'b1;
            push_val  = nxt;
            nxt       = trap_adr;
        end
    end

    // Sequencer FSM: one boot fetch of RESET_ADDR, then one word per ready cycle.
    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        rom_a_d  = nxt;
        cen_d    = 1'b0;
        mc_vld   = 1'b0;
        trap_ack = 1'b0;
        case (state_q)
            BOOT: begin
                rom_a_d = RESET_ADDR;
                cen_d   = 1'b1;
                upc_d   = RESET_ADDR;
                state_d = RUN;
            end
            RUN: begin
                if (ready) begin
                    cen_d    = 1'b1;
                    mc_vld   = 1'b1;
                    trap_ack = trap_take;
                    upc_d    = nxt;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and microaddress registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= BOOT;
            upc_q   <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
        end
    end

    // Return stack, top at index 0; pushing when full drops the oldest entry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
        end else if (push) begin
            for (int i = STK_DEPTH - 1; i > 0; i--) stk_q[i] <= stk_q[i-1];
            stk_q[0] <= push_val;
            if (cnt_q == CW'(STK_DEPTH)) err_q <= 1'b1;
            else                         cnt_q <= cnt_q + CW'(1);
        end else if (pop) begin
            for (int i = 0; i < STK_DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
            if (cnt_q == '0) err_q <= 1'b1;
            else             cnt_q <= cnt_q - CW'(1);
        end
    end

    // The FSM sits in BOOT while reset is held; keep the ROM disabled until release.
    assign rom.rom_cen = cen_d & nrst;
    assign rom.rom_a   = rom_a_d;
    assign mc_out      = rom.rom_mc;
    assign upc         = upc_q;
    assign stk_err     = err_q;

endmodule

// File: tb/tb_dc_useq.sv
// Bench for dc_useq: behavioural ROM, queue-based stack model, scoreboard
// of per-cycle expectations consumed by an independent monitor.
module tb_dc_useq;
    localparam int         DEPTH = 4;
    localparam logic [9:0] RST   = 10'h080;

    logic        clk  = 1'b0;
    logic        nrst = 1'b1;
    logic        ax = 1'b0, ready = 1'b1, trap_req = 1'b0;
    logic [8:0]  pla_adr = '0;
    logic [3:0]  cond = '0;
    logic [9:0]  trap_adr = '0;
    logic        trap_ack, mc_vld, stk_err;
    logic [15:0] mc_out;
    logic [9:0]  upc;

    dc_useq_if rif ();

    dc_useq #(.STK_DEPTH(DEPTH), .RESET_ADDR(RST)) dut (
        .clk(clk), .nrst(nrst), .rom(rif), .ax(ax), .pla_adr(pla_adr),
        .cond(cond), .ready(ready), .trap_req(trap_req), .trap_adr(trap_adr),
        .trap_ack(trap_ack), .mc_out(mc_out), .mc_vld(mc_vld), .upc(upc),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    // Registered ROM: word {mc[15:0], ma[8:0]} appears the cycle after an enabled fetch.
    logic [24:0] mem [1024];
    always @(posedge clk) begin
        if (rif.rom_cen) begin
            rif.rom_mc <= mem[rif.rom_a][24:9];
            rif.rom_ma <= mem[rif.rom_a][8:0];
        end
    end

    typedef struct packed {
        logic vld, cen, ack, err, ca, hk;
        logic [9:0] a, upc, k;
        logic [15:0] mc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0, n_fail = 0;
    bit         m_boot;
    logic [9:0] m_upc;
    logic [9:0] m_stk[$];
    bit         m_err;
    int         stall_left;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mpush(input logic [9:0] v);
        if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_back());
            m_err = 1'b1;
        end
        m_stk.push_front(v);
    endtask

    task automatic put(input logic [9:0] a, input logic [2:0] op, input logic [8:0] ma);
        mem[a] = {op, 13'($urandom), ma};
    endtask

    // Directed program: SEQ/BR arithmetic, CALL/RET, PLA with deferred trap,
    // five nested CALLs (overflow) and RETs down to an empty stack.
    task automatic load_directed();
        for (int i = 0; i < 1024; i++) mem[i] = {16'h0000, 9'h080};
        put(10'h080, 3'b000, 9'h012);
        put(10'h212, 3'b110, 9'h040);
        put(10'h241, 3'b110, 9'h040);
        put(10'h240, 3'b000, 9'h085);
        put(10'h085, 3'b001, 9'h100);
        put(10'h100, 3'b011, 9'h000);
        put(10'h0C0, 3'b000, 9'h033);
        put(10'h300, 3'b010, 9'h000);
        put(10'h033, 3'b010, 9'h000);
        put(10'h086, 3'b001, 9'h1A0);
        put(10'h1A0, 3'b001, 9'h1B0);
        put(10'h1B0, 3'b001, 9'h1C0);
        put(10'h1C0, 3'b001, 9'h1D0);
        put(10'h1D0, 3'b001, 9'h1E0);
        put(10'h1E0, 3'b010, 9'h000);
        put(10'h1D1, 3'b010, 9'h000);
        put(10'h1C1, 3'b010, 9'h000);
        put(10'h1B1, 3'b010, 9'h000);
        put(10'h1A1, 3'b010, 9'h000);
    endtask

    // Hand-derived next addresses for the directed program.
    function automatic logic [10:0] kexp(input logic [9:0] a);
        case (a)
            10'h080: return {1'b1, 10'h212};
            10'h212: return {1'b1, 10'h241};
            10'h241: return {1'b1, 10'h240};
            10'h085: return {1'b1, 10'h100};
            10'h100: return {1'b1, 10'h0C0};
            10'h0C0: return {1'b1, 10'h300};
            10'h300: return {1'b1, 10'h033};
            10'h033: return {1'b1, 10'h086};
            10'h1A1: return {1'b1, 10'h080};
            default: return 11'h0;
        endcase
    endfunction

    // One cycle: choose inputs, predict the DUT's outputs, queue the expectation.
    task automatic step(input bit directed);
        exp_t        e;
        logic [15:0] mc;
        logic [8:0]  ma;
        logic [9:0]  nxt;
        logic [10:0] kk;
        if (directed) begin
            ax       = m_upc inside {10'h080, 10'h212, 10'h241, 10'h300, 10'h033};
            cond     = (m_upc == 10'h212) ? 4'b0100 : 4'b0000;
            pla_adr  = 9'h0C0;
            trap_req = m_upc inside {10'h100, 10'h0C0};
            trap_adr = 10'h300;
            ready    = 1'b1;
            if (!m_boot && m_upc == 10'h085 && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end
        end else begin
            ax       = 1'($urandom);
            cond     = 4'($urandom);
            pla_adr  = 9'($urandom);
            trap_req = ($urandom_range(0, 2) == 0);
            trap_adr = 10'($urandom);
            ready    = ($urandom_range(0, 3) != 0);
        end
        e     = '0;
        e.err = m_err;
        e.upc = m_upc;
        if (m_boot) begin
            e.cen = 1'b1; e.ca = 1'b1; e.a = RST;
            m_boot = 1'b0;
            m_upc  = RST;
        end else if (ready) begin
            mc = mem[m_upc][24:9];
            ma = mem[m_upc][8:0];
            e.vld = 1'b1; e.cen = 1'b1; e.ca = 1'b1; e.mc = mc;
            case (mc[15:13])
                3'd0: nxt = {ax, ma};
                3'd1: begin mpush(10'(m_upc + 10'd1)); nxt = {ax, ma}; end
                3'd2: begin
                    if (m_stk.size() == 0) begin nxt = RST; m_err = 1'b1; end
                    else nxt = m_stk.pop_front();
                end
                3'd3: nxt = {ax, pla_adr};
                default: begin
                    nxt = {ax, ma};
                    if (cond[mc[14:13]]) nxt[0] = 1'b1;
                end
            endcase
            if (trap_req && (mc[15:13] == 3'd0 || mc[15])) begin
                mpush(nxt);
                nxt   = trap_adr;
                e.ack = 1'b1;
            end
            if (directed) begin
                kk   = kexp(m_upc);
                e.hk = kk[10];
                e.k  = kk[9:0];
            end
            e.a   = nxt;
            m_upc = nxt;
        end
        sb.push_back(e);
    endtask

    // Monitor: each cycle's presented outputs against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rom_cen", 32'(rif.rom_cen), 32'(e.cen));
            chk("mc_vld", 32'(mc_vld), 32'(e.vld));
            chk("trap_ack", 32'(trap_ack), 32'(e.ack));
            chk("upc", 32'(upc), 32'(e.upc));
            chk("stk_err", 32'(stk_err), 32'(e.err));
            if (e.ca)  chk("rom_a", 32'(rif.rom_a), 32'(e.a));
            if (e.vld) chk("mc_out", 32'(mc_out), 32'(e.mc));
            if (e.hk)  chk("rom_a_directed", 32'(rif.rom_a), 32'(e.k));
        end
    end

    // Assert reset away from the edge, check reset outputs, optionally reload ROM, release.
    task automatic do_reset(input bit directed, input bit load_rand);
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        chk("rst_rom_cen", 32'(rif.rom_cen), 32'd0);
        chk("rst_mc_vld", 32'(mc_vld), 32'd0);
        chk("rst_trap_ack", 32'(trap_ack), 32'd0);
        chk("rst_rom_a", 32'(rif.rom_a), 32'(RST));
        chk("rst_upc", 32'(upc), 32'(RST));
        chk("rst_stk_err", 32'(stk_err), 32'd0);
        if (load_rand)
            for (int i = 0; i < 1024; i++) mem[i] = {16'($urandom), 9'($urandom)};
        @(posedge clk);
        @(posedge clk); #1;
        nrst       = 1'b1;
        m_boot     = 1'b1;
        m_upc      = RST;
        m_err      = 1'b0;
        m_stk.delete();
        stall_left = 3;
        step(directed);
    endtask

    initial begin
        load_directed();
        do_reset(1'b1, 1'b0);
        repeat (50) begin @(posedge clk); #1; step(1'b1); end
        do_reset(1'b1, 1'b0);
        repeat (30) begin @(posedge clk); #1; step(1'b1); end
        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0, 1'b1);
            repeat (700) begin @(posedge clk); #1; step(1'b0); end
        end
        do_reset(1'b0, 1'b0);
        repeat (200) begin @(posedge clk); #1; step(1'b0); end
        @(negedge clk); #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
